// File: rtl/display_pkg.sv
// Shared seven-segment definitions for the display encoder and the scan decoder.
package display_pkg;

   localparam int NUM_DIGITS = 4;

   // Bit positions of each segment within the 8-bit segment bus
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Lit segments a..g packed as {a,b,c,d,e,f,g}
   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_HEX [0:15] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

endpackage

// File: rtl/display_decoder_if.sv
// Scan bus between the display driver (master) and the scan decoder (slave).
interface display_decoder_if;
   import display_pkg::*;

   logic [7:0]              digit;
   logic [7:0]              segment;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   points;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    valid;
   logic                    error;

   modport master (output digit, output segment,
                   input value, input points, input blank, input valid, input error);

   modport slave  (input digit, input segment,
                   output value, output points, output blank, output valid, output error);

endinterface

// File: rtl/seg7_decode.sv
// Maps a lit-segment pattern back to a hex nibble, flagging blank and unknown patterns.
module seg7_decode
   import display_pkg::*;
(
   input  seg7_t      lit,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       illegal
);

   // Table lookup against the shared encoder patterns
   always_comb begin
      nibble  = 4'h0;
      blank   = 1'b0;
      illegal = 1'b0;
      if (lit == 7'h00) begin
         blank = 1'b1;
      end else begin
         illegal = 1'b1;
         for (int i = 0; i < 16; i++) begin
            if (lit == SEG_HEX[i]) begin
               nibble  = 4'(i);
               illegal = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/display_decoder.sv
// Monitors the multiplexed seven-segment scan and rebuilds the rightmost four digits.
module display_decoder
   import display_pkg::*;
#(
   parameter int SETTLE = 4
) (
   input  logic             clock,
   input  logic             reset,
   display_decoder_if.slave bus
);

   localparam logic [7:0] STAB_MAX  = 8'(SETTLE);
   localparam logic [7:0] SAMPLE_AT = 8'(SETTLE - 1);

   logic [7:0]                       digit_q, digit_d;
   logic [7:0]                       stab_q, stab_d;
   logic [NUM_DIGITS-1:0]            captured_q, captured_d;
   logic                             frame_err_q, frame_err_d;
   logic [NUM_DIGITS-1:0][3:0]       sh_nib_q, sh_nib_d;
   logic [NUM_DIGITS-1:0]            sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]            sh_blank_q, sh_blank_d;
   logic [NUM_DIGITS-1:0][3:0]       value_q, value_d;
   logic [NUM_DIGITS-1:0]            points_q, points_d;
   logic [NUM_DIGITS-1:0]            blank_q, blank_d;
   logic                             valid_q, valid_d;
   logic                             error_q, error_d;

   logic [NUM_DIGITS-1:0] strobe_low;
   logic                  one_hot, legal, idle, illegal_strobe;
   logic [7:0]            stab_cur;
   logic                  settled, sample, bad_strobe;
   seg7_t                 lit;
   logic [3:0]            dec_nib;
   logic                  dec_blank, dec_illegal;
   logic [NUM_DIGITS-1:0] cap_next;
   logic                  err_next;

   assign lit = ~bus.segment[SEG_A:SEG_G];

   seg7_decode u_seg7_decode (
      .lit     (lit),
      .nibble  (dec_nib),
      .blank   (dec_blank),
      .illegal (dec_illegal)
   );

   // Strobe classification and stability tracking; the settle event fires once per stable epoch
   always_comb begin
      strobe_low     = ~bus.digit[NUM_DIGITS-1:0];
      one_hot        = (strobe_low != '0) && ((strobe_low & (strobe_low - 1'b1)) == '0);
      legal          = (&bus.digit[7:NUM_DIGITS]) && one_hot;
      idle           = &bus.digit;
      illegal_strobe = !legal && !idle;
      if (bus.digit != digit_q)
         stab_cur = 8'd0;
      else if (stab_q >= STAB_MAX)
         stab_cur = STAB_MAX;
      else
         stab_cur = stab_q + 8'd1;
      settled    = (stab_cur == SAMPLE_AT);
      sample     = legal && settled;
      bad_strobe = illegal_strobe && settled;
   end

   // Shadow capture and frame completion; a completing frame publishes including its final sample
   always_comb begin
      digit_d     = bus.digit;
      stab_d      = stab_cur;
      sh_nib_d    = sh_nib_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      value_d     = value_q;
      points_d    = points_q;
      blank_d     = blank_q;
      error_d     = error_q;
      valid_d     = 1'b0;
      cap_next    = captured_q;
      if (sample) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (strobe_low[i]) begin
               sh_nib_d[i]   = dec_nib;
               sh_dp_d[i]    = ~bus.segment[SEG_DP];
               sh_blank_d[i] = dec_blank;
            end
         end
         cap_next = captured_q | strobe_low;
      end
      err_next    = frame_err_q | (sample && dec_illegal) | bad_strobe;
      captured_d  = cap_next;
      frame_err_d = err_next;
      if (sample && (cap_next == '1)) begin
         value_d     = sh_nib_d;
         points_d    = sh_dp_d;
         blank_d     = sh_blank_d;
         error_d     = err_next;
         valid_d     = 1'b1;
         captured_d  = '0;
         frame_err_d = 1'b0;
      end
   end

   // State registers; reset discards any partial frame
   always_ff @(posedge clock) begin
      if (reset) begin
         digit_q     <= 8'hFF;
         stab_q      <= 8'd0;
         captured_q  <= '0;
         frame_err_q <= 1'b0;
         sh_nib_q    <= '0;
         sh_dp_q     <= '0;
         sh_blank_q  <= '0;
         value_q     <= '0;
         points_q    <= '0;
         blank_q     <= '1;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         digit_q     <= digit_d;
         stab_q      <= stab_d;
         captured_q  <= captured_d;
         frame_err_q <= frame_err_d;
         sh_nib_q    <= sh_nib_d;
         sh_dp_q     <= sh_dp_d;
         sh_blank_q  <= sh_blank_d;
         value_q     <= value_d;
         points_q    <= points_d;
         blank_q     <= blank_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign bus.value  = value_q;
   assign bus.points = points_q;
   assign bus.blank  = blank_q;
   assign bus.valid  = valid_q;
   assign bus.error  = error_q;

endmodule
